// File: rtl/stack_lifo_if.sv
// Operand-stack bus: push/pop strobes from the producer, top-of-stack and status back from the stack.
interface stack_lifo_if #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 20
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             PUSH_STB;
    logic [WIDTH-1:0] PUSH_DAT;
    logic             POP_STB;
    logic [WIDTH-1:0] POP_DAT;
    logic [CNT_W-1:0] COUNT;
    logic             EMPTY;
    logic             FULL;
    logic             OVERFLOW;
    logic             UNDERFLOW;

    modport master (
        output PUSH_STB, PUSH_DAT, POP_STB,
        input  POP_DAT, COUNT, EMPTY, FULL, OVERFLOW, UNDERFLOW
    );

    modport slave (
        input  PUSH_STB, PUSH_DAT, POP_STB,
        output POP_DAT, COUNT, EMPTY, FULL, OVERFLOW, UNDERFLOW
    );
endinterface

// File: rtl/stack_lifo.sv
// LIFO operand stack for the RPN datapath; top entry is always presented on POP_DAT (show-ahead).
module stack_lifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 20
) (
    input  logic          CLK,
    input  logic          RST,
    stack_lifo_if.slave   bus
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [CNT_W-1:0] cnt;
    logic             overflow;
    logic             underflow;

    logic             is_empty;
    logic             is_full;
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] top_idx;

    assign is_empty = (cnt == '0);
    assign is_full  = (cnt == CNT_W'(DEPTH));
    assign wr_idx   = IDX_W'(cnt);
    assign top_idx  = IDX_W'(cnt - CNT_W'(1));

    // Simultaneous push+pop on a non-empty stack overwrites the top in place.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt       <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
            unique case ({bus.PUSH_STB, bus.POP_STB})
                2'b10: begin
                    if (is_full) begin
                        overflow <= 1'b1;
                    end else begin
                        mem[wr_idx] <= bus.PUSH_DAT;
                        cnt         <= cnt + CNT_W'(1);
                    end
                end
                2'b01: begin
                    if (is_empty) begin
                        underflow <= 1'b1;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                2'b11: begin
                    if (is_empty) begin
                        mem[wr_idx] <= bus.PUSH_DAT;
                        cnt         <= CNT_W'(1);
                        underflow   <= 1'b1;
                    end else begin
                        mem[top_idx] <= bus.PUSH_DAT;
                    end
                end
                default: ;
            endcase
        end
    end

    // Stale slots above the pointer are never shown: empty forces zero.
    assign bus.POP_DAT   = is_empty ? '0 : mem[top_idx];
    assign bus.COUNT     = cnt;
    assign bus.EMPTY     = is_empty;
    assign bus.FULL      = is_full;
    assign bus.OVERFLOW  = overflow;
    assign bus.UNDERFLOW = underflow;
endmodule

// File: tb/tb_stack_lifo.sv
// Scoreboard bench for stack_lifo: a queue-based stack model predicts each cycle's outputs.
module tb_stack_lifo;
    localparam int WIDTH = 64;
    localparam int DEPTH = 20;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic CLK = 1'b0;
    logic RST;

    always #5 CLK = ~CLK;

    stack_lifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    stack_lifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    typedef struct packed {
        logic [WIDTH-1:0] dat;
        logic [CNT_W-1:0] cnt;
        logic             empty;
        logic             full;
        logic             ovf;
        logic             unf;
    } exp_t;

    exp_t             sb[$];
    logic [WIDTH-1:0] model[$];
    int               n_checks = 0;
    int               n_pass   = 0;

    task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    endtask

    function automatic exp_t model_state(input bit ovf, input bit unf);
        exp_t e;
        e.dat   = (model.size() != 0) ? model[$] : '0;
        e.cnt   = CNT_W'(model.size());
        e.empty = (model.size() == 0);
        e.full  = (model.size() == DEPTH);
        e.ovf   = ovf;
        e.unf   = unf;
        return e;
    endfunction

    function automatic exp_t reset_state();
        exp_t e;
        e.dat = '0; e.cnt = '0; e.empty = 1'b1; e.full = 1'b0; e.ovf = 1'b0; e.unf = 1'b0;
        return e;
    endfunction

    task automatic check_state(input string tag, input exp_t e);
        check({tag, ".pop_dat"},   bus.POP_DAT,          e.dat);
        check({tag, ".count"},     64'(bus.COUNT),       64'(e.cnt));
        check({tag, ".empty"},     64'(bus.EMPTY),       64'(e.empty));
        check({tag, ".full"},      64'(bus.FULL),        64'(e.full));
        check({tag, ".overflow"},  64'(bus.OVERFLOW),    64'(e.ovf));
        check({tag, ".underflow"}, 64'(bus.UNDERFLOW),   64'(e.unf));
    endtask

    // Drive one cycle of stimulus and enqueue the model's prediction for the following edge.
    task automatic step(input bit push, input bit pop, input logic [WIDTH-1:0] d);
        bit ovf = 1'b0;
        bit unf = 1'b0;
        @(negedge CLK);
        bus.PUSH_STB = push;
        bus.POP_STB  = pop;
        bus.PUSH_DAT = d;
        if (push && pop) begin
            if (model.size() == 0) begin
                model.push_back(d);
                unf = 1'b1;
            end else begin
                void'(model.pop_back());
                model.push_back(d);
            end
        end else if (push) begin
            if (model.size() == DEPTH) ovf = 1'b1;
            else model.push_back(d);
        end else if (pop) begin
            if (model.size() == 0) unf = 1'b1;
            else void'(model.pop_back());
        end
        sb.push_back(model_state(ovf, unf));
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge CLK);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check_state("cyc", e);
            end
        end
    end

    initial begin : stim
        int r;
        int push_pct;
        RST          = 1'b1;
        bus.PUSH_STB = 1'b0;
        bus.POP_STB  = 1'b0;
        bus.PUSH_DAT = '0;
        repeat (2) @(posedge CLK);
        #1;
        check_state("reset", reset_state());
        #2 RST = 1'b0;

        // Idle after reset
        step(0, 0, 64'd0);
        step(0, 0, 64'd0);

        // Push 5,7,3 then pop three times
        step(1, 0, 64'd5);
        step(1, 0, 64'd7);
        step(1, 0, 64'd3);
        repeat (3) step(0, 1, 64'd0);

        // Fill to DEPTH, then overflow attempt
        for (int i = 1; i <= DEPTH; i++) step(1, 0, 64'(i));
        step(1, 0, 64'd99);
        step(0, 0, 64'd0);

        // Drain and pop once more on empty
        for (int i = 0; i <= DEPTH; i++) step(0, 1, 64'd0);
        step(0, 0, 64'd0);

        // Replace top on [4,9], then on a full stack, then push+pop on empty
        step(1, 0, 64'd4);
        step(1, 0, 64'd9);
        step(1, 1, 64'd13);
        step(0, 0, 64'd0);
        for (int i = 0; i < DEPTH - 2; i++) step(1, 0, {$urandom(), $urandom()});
        step(1, 1, 64'hDEAD_BEEF_0123_4567);
        step(0, 0, 64'd0);
        for (int i = 0; i < DEPTH; i++) step(0, 1, 64'd0);
        step(1, 1, 64'hFFFF_FFFF_FFFF_FFFF);
        step(0, 1, 64'd0);

        // Random traffic with alternating push-heavy / pop-heavy phases
        for (int i = 0; i < 800; i++) begin
            push_pct = ((i / 100) % 2 == 0) ? 70 : 30;
            r = $urandom_range(0, 99);
            if (r < 10)            step(1, 1, {$urandom(), $urandom()});
            else if (r < push_pct) step(1, 0, {$urandom(), $urandom()});
            else if (r < 92)       step(0, 1, 64'd0);
            else                   step(0, 0, 64'd0);
        end

        // Asynchronous reset in the middle of a cycle with live contents
        step(1, 0, 64'd11);
        step(1, 0, 64'd22);
        step(1, 0, 64'd33);
        @(posedge CLK);
        #3 RST = 1'b1;
        #1;
        check_state("async_rst", reset_state());
        model.delete();
        @(negedge CLK);
        bus.PUSH_STB = 1'b1;
        bus.POP_STB  = 1'b0;
        bus.PUSH_DAT = 64'd77;
        sb.push_back(reset_state());
        @(posedge CLK);
        #2;
        bus.PUSH_STB = 1'b0;
        #1 RST = 1'b0;
        step(1, 0, 64'd42);
        step(0, 0, 64'd0);
        step(0, 1, 64'd0);

        @(posedge CLK);
        #2;
        check("sb_drain", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
